vis_stream_packer: RTL and testbench
====================================

Name: vis_stream_packer

Overview:
- Downstream of the correlator's bus-side visibility output.
- Consumes one complex visibility per handshake: a real word and an imaginary word with valid/ready/last.
- Serialises each visibility into a framed, byte-wide AXI-Stream. The stream carries a sync header, a frame sequence number and an XOR checksum trailer.
- Feeds the UART/USB byte transports in the bus clock domain. It replaces the address-decoded byte-select mux used by the SPI path.

Parameters:
- WORD_BITS, 32: width of each real/imag visibility word. Must be a multiple of 8 and at least 8.
- HEADER_EN, 1: 1 = prefix each frame with SYNC_WORD (MSB byte first) and then the sequence byte. 0 = no header.
- CSUM_EN, 1: 1 = append the XOR checksum byte after the last payload byte. 0 = no trailer.
- SYNC_WORD, 16'hA55A: 2-byte frame sync pattern.

Ports:
- aclk  in  1  bus clock; all logic on the rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- s_revis_i  in  WORD_BITS  real visibility word.
- s_imvis_i  in  WORD_BITS  imaginary visibility word.
- s_valid_i  in  1  input word valid.
- s_ready_o  out  1  input word accepted when s_valid_i && s_ready_o.
- s_last_i  in  1  marks the final visibility of a frame.
- m_tvalid_o  out  1  output byte valid.
- m_tready_i  in  1  downstream ready.
- m_tlast_o  out  1  final byte of the frame.
- m_tdata_o  out  8  output byte.
- busy_o  out  1  high whenever state != IDLE.
- seq_o  out  8  current frame sequence number.

Behaviour:
- Clock and reset: one clock, aclk. Reset aresetn is asynchronous and active-low.
- Reset values:
  - m_tvalid_o=0, m_tlast_o=0, m_tdata_o=0x00.
  - s_ready_o=0 while aresetn is low.
  - busy_o=0, seq_o=0x00, checksum=0x00, state=IDLE.
- Output rules:
  - m_tdata_o, m_tvalid_o and m_tlast_o are registered.
  - While m_tvalid_o && !m_tready_i, all three hold stable.
  - A byte advances only on m_tvalid_o && m_tready_i.
- s_ready_o is combinational from state: high only in IDLE and WAIT.
- States: IDLE, HDR0, HDR1, SEQ, DATA, WAIT, CSUM.
- IDLE, on input accept:
  - Latch {re, im} into the shift register and latch s_last_i.
  - Clear the checksum.
  - Next state is HDR0 if HEADER_EN, else DATA.
- HDR0 / HDR1 / SEQ emit SYNC_WORD[15:8], then SYNC_WORD[7:0], then seq_o. Header bytes are excluded from the checksum.
- DATA:
  - Emits NB = 2*WORD_BITS/8 bytes: real word MSB first, then imag word MSB first.
  - Each accepted byte is XORed into the checksum.
  - After the last byte of the word is accepted:
    - if the latched last=0, go to WAIT;
    - else go to CSUM if CSUM_EN;
    - else go to IDLE, with m_tlast_o having been asserted on that final data byte.
- WAIT: on input accept, latch the new word and last flag, then go to DATA. No header and no checksum clear.
- CSUM: emits the checksum with m_tlast_o=1. On handshake, seq_o increments (wraps 0xFF to 0x00) and the state returns to IDLE.
- When CSUM_EN=0, seq_o increments on the tlast data byte handshake instead.
- Latency: input accept at cycle t puts the first output byte (header or data) valid at t+1.
- Throughput: one idle output cycle per visibility word. Sustained rate is NB bytes per NB+1 cycles.
- m_tlast_o is asserted exactly once per frame. It never appears on header bytes or on non-final words.
- s_valid_i is ignored in HDR*/SEQ/DATA/CSUM because s_ready_o=0 there. Input data may change freely while it is not being accepted.
- If aresetn is asserted mid-frame:
  - outputs clear immediately (asynchronously) and the partial frame is discarded;
  - seq_o returns to 0x00;
  - the next frame after release starts with a full header.
- Counter widths:
  - byte index width is clog2(NB);
  - checksum is 8-bit XOR, initial value 0x00;
  - no saturation anywhere.

Test Plan:
- Single-word frame, defaults: re=0x01020304, im=0x05060708, last=1, tready=1. Required output: A5 5A 00 01 02 03 04 05 06 07 08 08, with tlast only on the final 0x08; then seq_o=0x01.
- Two-word frame: words {0x11111111, 0x22222222} last=0, then {0x33333333, 0x44444444} last=1. Required output: header, 16 payload bytes, checksum 0x00. One tvalid gap between the words; tlast asserted once.
- Backpressure: repeat the single-word frame with m_tready_i toggling every cycle and random stalls. The byte sequence must be identical, tdata/tlast stable during stalls, and no byte dropped or duplicated.
- Sequence wrap: send 257 single-word frames. Sequence bytes must run 0x00..0xFF, then 0x00.
- Parameter variants: HEADER_EN=0, CSUM_EN=0, single-word frame. Output is exactly 01..08 with tlast on 0x08. s_ready_o is high the cycle after the final handshake.
- Async reset mid-frame: drop aresetn after the 5th byte handshake. m_tvalid_o must go low without waiting for a clock edge. After release, the next frame emits A5 5A 00 and the full payload.

Source files
------------

// File: rtl/vis_stream_packer.sv
// Visibility stream packer: frames {re, im} word pairs into a byte-wide
// AXI-Stream with sync header, sequence byte and XOR checksum trailer.
module vis_stream_packer #(
  parameter int unsigned WORD_BITS = 32,
  parameter bit          HEADER_EN = 1'b1,
  parameter bit          CSUM_EN   = 1'b1,
  parameter logic [15:0] SYNC_WORD = 16'hA55A
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [WORD_BITS-1:0] s_revis_i,
  input  logic [WORD_BITS-1:0] s_imvis_i,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  input  logic                 s_last_i,
  output logic                 m_tvalid_o,
  input  logic                 m_tready_i,
  output logic                 m_tlast_o,
  output logic [7:0]           m_tdata_o,
  output logic                 busy_o,
  output logic [7:0]           seq_o
);

  localparam int unsigned NB = 2 * WORD_BITS / 8;
  localparam int unsigned SW = 2 * WORD_BITS;
  localparam int unsigned IW = $clog2(NB);
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  typedef enum logic [2:0] {
    IDLE, HDR0, HDR1, SEQ, DATA, WAIT, CSUM
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] sr_q, sr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          last_q, last_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    seq_q, seq_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          tlast_q, tlast_d;

  logic          acc;
  logic          hs;
  logic [SW-1:0] in_word;
  logic [IW-1:0] idx_nx;
  logic [7:0]    csum_nx;

  assign in_word = {s_revis_i, s_imvis_i};
  assign s_ready_o = aresetn &&
                     (state_q == IDLE || state_q == WAIT);
  assign acc     = s_valid_i && s_ready_o;
  assign hs      = valid_q && m_tready_i;
  assign idx_nx  = idx_q + 1'b1;
  assign csum_nx = csum_q ^ data_q;

  assign m_tvalid_o = valid_q;
  assign m_tlast_o  = tlast_q;
  assign m_tdata_o  = data_q;
  assign busy_o     = (state_q != IDLE);
  assign seq_o      = seq_q;

  // The state names the byte currently presented on the output register.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    last_d  = last_q;
    csum_d  = csum_q;
    seq_d   = seq_q;
    data_d  = data_q;
    valid_d = valid_q;
    tlast_d = tlast_q;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          last_d  = s_last_i;
          csum_d  = 8'h00;
          valid_d = 1'b1;
          tlast_d = 1'b0;
          idx_d   = '0;
          if (HEADER_EN) begin
            state_d = HDR0;
            sr_d    = in_word;
            data_d  = SYNC_WORD[15:8];
          end else begin
            state_d = DATA;
            sr_d    = in_word << 8;
            data_d  = s_revis_i[WORD_BITS-1 -: 8];
          end
        end
      end
      HDR0: begin
        if (hs) begin
          state_d = HDR1;
          data_d  = SYNC_WORD[7:0];
        end
      end
      HDR1: begin
        if (hs) begin
          state_d = SEQ;
          data_d  = seq_q;
        end
      end
      SEQ: begin
        if (hs) begin
          state_d = DATA;
          data_d  = sr_q[SW-1 -: 8];
          sr_d    = sr_q << 8;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (hs) begin
          csum_d = csum_nx;
          if (idx_q == LAST_IDX) begin
            if (!last_q) begin
              state_d = WAIT;
              valid_d = 1'b0;
              tlast_d = 1'b0;
            end else if (CSUM_EN) begin
              state_d = CSUM;
              data_d  = csum_nx;
              tlast_d = 1'b1;
            end else begin
              state_d = IDLE;
              valid_d = 1'b0;
              tlast_d = 1'b0;
              seq_d   = seq_q + 8'd1;
            end
          end else begin
            data_d  = sr_q[SW-1 -: 8];
            sr_d    = sr_q << 8;
            idx_d   = idx_nx;
            tlast_d = (idx_nx == LAST_IDX) && last_q && !CSUM_EN;
          end
        end
      end
      WAIT: begin
        if (acc) begin
          state_d = DATA;
          last_d  = s_last_i;
          sr_d    = in_word << 8;
          data_d  = s_revis_i[WORD_BITS-1 -: 8];
          valid_d = 1'b1;
          tlast_d = 1'b0;
          idx_d   = '0;
        end
      end
      CSUM: begin
        if (hs) begin
          state_d = IDLE;
          valid_d = 1'b0;
          tlast_d = 1'b0;
          seq_d   = seq_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      csum_q  <= 8'h00;
      seq_q   <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      tlast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      csum_q  <= csum_d;
      seq_q   <= seq_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      tlast_q <= tlast_d;
    end
  end

endmodule

// File: tb/tb_vis_stream_packer.sv
// Bench for vis_stream_packer: default and header/checksum-less instances,
// queue scoreboard fed by a frame-level reference model.
module tb_vis_stream_packer;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] re_d [2];
  logic [31:0] im_d [2];
  logic        v_d  [2];
  logic        l_d  [2];
  logic        tr_d [2];
  logic        rdy0, rdy1, tv0, tv1, tl0, tl1, busy0, busy1;
  logic [7:0]  td0, td1, seq0, seq1;

  always #5 aclk = ~aclk;

  vis_stream_packer dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_revis_i(re_d[0]), .s_imvis_i(im_d[0]),
    .s_valid_i(v_d[0]), .s_ready_o(rdy0), .s_last_i(l_d[0]),
    .m_tvalid_o(tv0), .m_tready_i(tr_d[0]), .m_tlast_o(tl0),
    .m_tdata_o(td0), .busy_o(busy0), .seq_o(seq0)
  );

  vis_stream_packer #(.HEADER_EN(1'b0), .CSUM_EN(1'b0)) dut2 (
    .aclk(aclk), .aresetn(aresetn),
    .s_revis_i(re_d[1]), .s_imvis_i(im_d[1]),
    .s_valid_i(v_d[1]), .s_ready_o(rdy1), .s_last_i(l_d[1]),
    .m_tvalid_o(tv1), .m_tready_i(tr_d[1]), .m_tlast_o(tl1),
    .m_tdata_o(td1), .busy_o(busy1), .seq_o(seq1)
  );

  int n_chk = 0;
  int n_pass = 0;

  logic [8:0]  q0 [$];
  logic [8:0]  q1 [$];
  logic [7:0]  mseq [2];
  int          hs_cnt [2];
  int          gap [2];
  int          last_gaps [2];
  bit          in_frame [2];
  bit          pstall [2];
  logic [7:0]  pdata [2];
  logic        plast [2];
  int          mode [2];
  logic [31:0] w_re [$];
  logic [31:0] w_im [$];
  logic [7:0]  lit0 [12];
  logic [7:0]  lit1 [8];

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
  endtask

  task automatic qpush(input int k, input logic [8:0] x);
    if (k == 0) q0.push_back(x);
    else q1.push_back(x);
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  // Reference: instance 0 has header+checksum, instance 1 has neither.
  task automatic push_frame(input int k);
    bit hdr;
    logic [7:0] cs;
    logic [7:0] b;
    logic [63:0] w;
    int n;
    hdr = (k == 0);
    cs = 8'h00;
    n = w_re.size();
    if (hdr) begin
      qpush(k, {1'b0, 8'hA5});
      qpush(k, {1'b0, 8'h5A});
      qpush(k, {1'b0, mseq[k]});
    end
    for (int i = 0; i < n; i++) begin
      w = {w_re[i], w_im[i]};
      for (int j = 0; j < 8; j++) begin
        b = w[63 - 8*j -: 8];
        cs = cs ^ b;
        qpush(k, {(!hdr && i == n - 1 && j == 7), b});
      end
    end
    if (hdr) qpush(k, {1'b1, cs});
    mseq[k] = mseq[k] + 8'd1;
  endtask

  task automatic mon(input int k, input logic v, input logic r,
                     input logic [7:0] d, input logic l);
    logic [8:0] e;
    bit have;
    if (!aresetn) begin
      pstall[k] = 0;
      in_frame[k] = 0;
      gap[k] = 0;
      return;
    end
    if (pstall[k])
      chk(v && d == pdata[k] && l == plast[k], "stall_hold",
          {v, l, d}, {1'b1, plast[k], pdata[k]});
    pstall[k] = v && !r;
    pdata[k] = d;
    plast[k] = l;
    if (!v && in_frame[k]) gap[k]++;
    if (v && r) begin
      hs_cnt[k]++;
      have = qsize(k) > 0;
      e = 9'h000;
      if (have) e = (k == 0) ? q0.pop_front() : q1.pop_front();
      chk(have && {l, d} == e, (k == 0) ? "byte0" : "byte1", {l, d}, e);
      if (l) begin
        last_gaps[k] = gap[k];
        gap[k] = 0;
        in_frame[k] = 0;
      end else begin
        in_frame[k] = 1;
      end
    end
  endtask

  always @(negedge aclk) begin
    mon(0, tv0, tr_d[0], td0, tl0);
    mon(1, tv1, tr_d[1], td1, tl1);
  end

  always @(posedge aclk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      case (mode[k])
        0: tr_d[k] = 1'b1;
        1: tr_d[k] = ~tr_d[k];
        2: tr_d[k] = 1'($urandom_range(0, 1));
        default: tr_d[k] = ($urandom_range(0, 3) == 0);
      endcase
    end
  end

  task automatic wait_ready(input int k);
    int t;
    t = 0;
    do begin
      @(negedge aclk);
      t++;
    end while (!((k == 0) ? rdy0 : rdy1) && t < 1000);
    chk(t < 1000, "ready_timeout", t, 1000);
  endtask

  task automatic send_words(input int k);
    int n;
    n = w_re.size();
    for (int i = 0; i < n; i++) begin
      re_d[k] = w_re[i];
      im_d[k] = w_im[i];
      l_d[k]  = (i == n - 1);
      v_d[k]  = 1'b1;
      wait_ready(k);
      @(posedge aclk);
      #1;
    end
    v_d[k]  = 1'b0;
    re_d[k] = $urandom;
    im_d[k] = $urandom;
    l_d[k]  = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input int k);
    int t;
    t = 0;
    while (qsize(k) != 0 && t < 5000) begin
      @(negedge aclk);
      #2;
      t++;
    end
    chk(qsize(k) == 0, "drain_timeout", qsize(k), 0);
    @(posedge aclk);
    #1;
    if (k == 0) begin
      chk(seq0 == mseq[0], "seq0", seq0, mseq[0]);
      chk(!busy0 && rdy0, "idle0", {busy0, rdy0}, 2'b01);
    end else begin
      chk(seq1 == mseq[1], "seq1", seq1, mseq[1]);
      chk(!busy1 && rdy1, "ready_after_last", {busy1, rdy1}, 2'b01);
    end
  endtask

  task automatic rand_words(input int n);
    w_re.delete();
    w_im.delete();
    for (int i = 0; i < n; i++) begin
      w_re.push_back($urandom);
      w_im.push_back($urandom);
    end
  endtask

  task automatic one_word(input logic [31:0] r, input logic [31:0] i);
    w_re.delete();
    w_im.delete();
    w_re.push_back(r);
    w_im.push_back(i);
  endtask

  task automatic model_frame(input int k, input int n, input int m);
    mode[k] = m;
    rand_words(n);
    push_frame(k);
    send_words(k);
    drain(k);
    chk(last_gaps[k] == n - 1, "word_gaps", last_gaps[k], n - 1);
  endtask

  task automatic do_reset();
    @(posedge aclk);
    #2;
    aresetn = 1'b0;
    q0.delete();
    q1.delete();
    mseq[0] = 8'h00;
    mseq[1] = 8'h00;
    #10;
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int t;
    lit0 = '{8'hA5, 8'h5A, 8'h00, 8'h01, 8'h02, 8'h03,
             8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08};
    lit1 = '{8'h01, 8'h02, 8'h03, 8'h04,
             8'h05, 8'h06, 8'h07, 8'h08};
    aresetn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      re_d[k] = '0; im_d[k] = '0; v_d[k] = 0; l_d[k] = 0;
      tr_d[k] = 1'b1; mode[k] = 0; mseq[k] = 8'h00;
      hs_cnt[k] = 0; gap[k] = 0; last_gaps[k] = 0;
      in_frame[k] = 0; pstall[k] = 0; pdata[k] = '0; plast[k] = 0;
    end
    #3;
    chk(!tv0 && !tl0 && td0 == 8'h00, "rst_out", {tv0, tl0, td0}, 0);
    chk(!rdy0 && !rdy1, "rst_ready", {rdy0, rdy1}, 0);
    chk(!busy0 && seq0 == 8'h00, "rst_state", {busy0, seq0}, 0);
    #20;
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    one_word(32'h01020304, 32'h05060708);
    for (int i = 0; i < 12; i++) qpush(0, {(i == 11), lit0[i]});
    mseq[0] = mseq[0] + 8'd1;
    send_words(0);
    drain(0);
    chk(seq0 == 8'h01, "seq_after_first", seq0, 8'h01);

    w_re.delete(); w_im.delete();
    w_re.push_back(32'h11111111); w_im.push_back(32'h22222222);
    w_re.push_back(32'h33333333); w_im.push_back(32'h44444444);
    push_frame(0);
    send_words(0);
    drain(0);
    chk(last_gaps[0] == 1, "two_word_gap", last_gaps[0], 1);

    for (int m = 1; m < 4; m++) begin
      mode[0] = m;
      one_word(32'h01020304, 32'h05060708);
      push_frame(0);
      send_words(0);
      drain(0);
    end
    mode[0] = 0;

    one_word(32'h01020304, 32'h05060708);
    for (int i = 0; i < 8; i++) qpush(1, {(i == 7), lit1[i]});
    mseq[1] = mseq[1] + 8'd1;
    send_words(1);
    drain(1);
    for (int r = 0; r < 6; r++)
      model_frame(1, $urandom_range(1, 3), $urandom_range(0, 3));

    for (int r = 0; r < 12; r++)
      model_frame(0, $urandom_range(1, 3), $urandom_range(0, 3));

    mode[0] = 0;
    one_word(32'h01020304, 32'h05060708);
    push_frame(0);
    base = hs_cnt[0];
    send_words(0);
    t = 0;
    while (hs_cnt[0] < base + 5 && t < 200) begin
      @(negedge aclk);
      #2;
      t++;
    end
    chk(t < 200, "hs5_timeout", t, 200);
    @(posedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    chk(!tv0 && !tl0, "async_tvalid", {tv0, tl0}, 0);
    chk(seq0 == 8'h00 && !busy0 && !rdy0, "async_state",
        {seq0, busy0, rdy0}, 0);
    q0.delete();
    q1.delete();
    mseq[0] = 8'h00;
    mseq[1] = 8'h00;
    #10;
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    push_frame(0);
    send_words(0);
    drain(0);

    do_reset();
    for (int f = 0; f < 257; f++) begin
      rand_words(1);
      push_frame(0);
      send_words(0);
      drain(0);
    end
    chk(seq0 == 8'h01, "seq_wrap", seq0, 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
